// File: rtl/dmac_pkg.sv
// Shared DMAC definitions: write-master FSM states, word size, byteenable lookup.
package dmac_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_POP,
    ST_LATCH,
    ST_WRITE,
    ST_ADVANCE,
    ST_DONE
  } wm_state_t;

  localparam int unsigned WORD_BYTES = 4;

  localparam logic [3:0] BE_FULL = 4'b1111;
  localparam logic [3:0] BE_REM1 = 4'b0001;
  localparam logic [3:0] BE_REM2 = 4'b0011;
  localparam logic [3:0] BE_REM3 = 4'b0111;

  // Little-endian byteenable for a final word holding 'rem' valid bytes.
  function automatic logic [3:0] be_for_tail(input logic [1:0] rem);
    case (rem)
      2'd1:    return BE_REM1;
      2'd2:    return BE_REM2;
      2'd3:    return BE_REM3;
      default: return BE_FULL;
    endcase
  endfunction

endpackage

// File: rtl/dma_wm_counter.sv
// Address / remaining-bytes register pair for a DMA master.
// load captures a new transfer; advance steps one word, remaining never underflows.
module dma_wm_counter
  import dmac_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                  iClk,
  input  logic                  iReset_n,
  input  logic                  load,
  input  logic                  advance,
  input  logic [ADDR_WIDTH-1:0] load_addr,
  input  logic [31:0]           load_len,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [31:0]           remaining
);

  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           remaining_q, remaining_d;

  // Next address/remaining: load has priority over advance.
  always_comb begin
    addr_d      = addr_q;
    remaining_d = remaining_q;
    if (load) begin
      addr_d      = load_addr;
      remaining_d = load_len;
    end else if (advance) begin
      addr_d      = addr_q + ADDR_WIDTH'(WORD_BYTES);
      remaining_d = (remaining_q >= 32'(WORD_BYTES)) ? remaining_q - 32'(WORD_BYTES) : '0;
    end
  end

  // Counter registers.
  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      addr_q      <= '0;
      remaining_q <= '0;
    end else begin
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
    end
  end

  assign addr      = addr_q;
  assign remaining = remaining_q;

endmodule

// File: rtl/dma_write_master.sv
// DMA write master: pops 32-bit words from the DMA FIFO and issues single-beat
// Avalon-MM writes to consecutive word addresses, one write outstanding.
// Optional build macro WM_BYTEENABLE_EN: honours Length[1:0] and adds oWM_byteenable.
module dma_write_master
  import dmac_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                  iClk,
  input  logic                  iReset_n,
  input  logic                  Start,
  input  logic [31:0]           Length,
  input  logic [ADDR_WIDTH-1:0] WM_startaddress,
  input  logic                  FF_empty,
  input  logic [DATA_WIDTH-1:0] FF_q,
  output logic                  FF_readrequest,
  output logic                  oWM_write,
  output logic [ADDR_WIDTH-1:0] oWM_writeaddress,
  output logic [DATA_WIDTH-1:0] oWM_writedata,
  input  logic                  iWM_waitrequest,
`ifdef WM_BYTEENABLE_EN
  output logic [3:0]            oWM_byteenable,
`endif
  output logic                  Busy,
  output logic                  Done
);

  wm_state_t             state_q, state_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  write_q, write_d;
  logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;

  logic                  cnt_load, cnt_advance, cnt_last, has_words, ff_pop;
  logic [31:0]           load_len, cnt_remaining;
  logic [ADDR_WIDTH-1:0] cnt_addr;

`ifdef WM_BYTEENABLE_EN
  logic [3:0]            be_q, be_d;
  assign has_words = (Length != '0);
  assign load_len  = Length;
`else
  assign has_words = (Length[31:2] != '0);
  assign load_len  = Length & ~32'(WORD_BYTES - 1);
`endif

  assign cnt_last = (cnt_remaining <= 32'(WORD_BYTES));

  dma_wm_counter #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_counter (
    .iClk      (iClk),
    .iReset_n  (iReset_n),
    .load      (cnt_load),
    .advance   (cnt_advance),
    .load_addr (WM_startaddress),
    .load_len  (load_len),
    .addr      (cnt_addr),
    .remaining (cnt_remaining)
  );

  // FSM next state and registered-output next values.
  // The pop strobe is decoded from the POP state and FF_empty so the FIFO
  // pops one cycle ahead of LATCH, where FF_q is then valid for capture.
  always_comb begin
    state_d     = state_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    write_d     = write_q;
    waddr_d     = waddr_q;
    wdata_d     = wdata_q;
    cnt_load    = 1'b0;
    cnt_advance = 1'b0;
    ff_pop      = 1'b0;
`ifdef WM_BYTEENABLE_EN
    be_d        = be_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (Start) begin
          busy_d = 1'b1;
          if (has_words) begin
            cnt_load = 1'b1;
            state_d  = ST_POP;
          end else begin
            done_d  = 1'b1;
            state_d = ST_DONE;
          end
        end
      end
      ST_POP: begin
        if (!FF_empty) begin
          ff_pop  = 1'b1;
          state_d = ST_LATCH;
        end
      end
      ST_LATCH: begin
        wdata_d = FF_q;
        waddr_d = cnt_addr;
        write_d = 1'b1;
`ifdef WM_BYTEENABLE_EN
        be_d    = (cnt_remaining >= 32'(WORD_BYTES)) ? BE_FULL : be_for_tail(cnt_remaining[1:0]);
`endif
        state_d = ST_WRITE;
      end
      ST_WRITE: begin
        if (!iWM_waitrequest) begin
          write_d = 1'b0;
          state_d = ST_ADVANCE;
        end
      end
      ST_ADVANCE: begin
        cnt_advance = 1'b1;
        if (cnt_last) begin
          done_d  = 1'b1;
          state_d = ST_DONE;
        end else begin
          state_d = ST_POP;
        end
      end
      ST_DONE: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers; reset aborts any transfer in flight.
  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      state_q <= ST_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      write_q <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
`ifdef WM_BYTEENABLE_EN
      be_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      write_q <= write_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
`ifdef WM_BYTEENABLE_EN
      be_q    <= be_d;
`endif
    end
  end

  assign FF_readrequest   = ff_pop;
  assign oWM_write        = write_q;
  assign oWM_writeaddress = waddr_q;
  assign oWM_writedata    = wdata_q;
  assign Busy             = busy_q;
  assign Done             = done_q;
`ifdef WM_BYTEENABLE_EN
  assign oWM_byteenable   = be_q;
`endif

endmodule

// File: tb/tb_dma_write_master.sv
// Self-checking bench for dma_write_master: FIFO model, Avalon slave with
// directed/random waitrequest, and a scoreboard of expected (address, data) beats.
module tb_dma_write_master;

  logic        iClk            = 1'b0;
  logic        iReset_n        = 1'b0;
  logic        Start           = 1'b0;
  logic [31:0] Length          = '0;
  logic [31:0] WM_startaddress = '0;
  logic        FF_empty        = 1'b1;
  logic [31:0] FF_q            = '0;
  logic        iWM_waitrequest = 1'b0;
  logic        FF_readrequest, oWM_write, Busy, Done;
  logic [31:0] oWM_writeaddress, oWM_writedata;
`ifdef WM_BYTEENABLE_EN
  logic [3:0]  oWM_byteenable;
`endif

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  logic [31:0] fifo[$];
  logic [31:0] exp_addr[$];
  logic [31:0] exp_data[$];
  logic [3:0]  exp_be[$];

  bit          fifo_block = 1'b0;
  bit          rand_mode  = 1'b0;
  int unsigned wait_hold  = 0;
  int unsigned cyc_n = 0, done_cnt = 0, done_cyc = 0, first_wr_cyc = 0;
  int unsigned pop_cnt = 0, beat_cnt = 0, stall_cycles = 0, stall_bad = 0;
  int unsigned bad_pop = 0, extra_beats = 0;
  bit          prev_stall = 1'b0;
  logic [31:0] prev_addr = '0, prev_data = '0;

  always #5 iClk = ~iClk;

  dma_write_master #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(32)
  ) dut (
    .iClk             (iClk),
    .iReset_n         (iReset_n),
    .Start            (Start),
    .Length           (Length),
    .WM_startaddress  (WM_startaddress),
    .FF_empty         (FF_empty),
    .FF_q             (FF_q),
    .FF_readrequest   (FF_readrequest),
    .oWM_write        (oWM_write),
    .oWM_writeaddress (oWM_writeaddress),
    .oWM_writedata    (oWM_writedata),
    .iWM_waitrequest  (iWM_waitrequest),
`ifdef WM_BYTEENABLE_EN
    .oWM_byteenable   (oWM_byteenable),
`endif
    .Busy             (Busy),
    .Done             (Done)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // One clock cycle: observe mid-cycle, then advance the FIFO and slave models.
  task automatic cyc();
    bit rd, wr, st, emp;
    #4;
    rd  = FF_readrequest;
    wr  = oWM_write;
    st  = iWM_waitrequest;
    emp = FF_empty;
    if (rd) begin
      pop_cnt++;
      if (emp) bad_pop++;
    end
    if (wr && first_wr_cyc == 0) first_wr_cyc = cyc_n;
    if (wr && prev_stall && (oWM_writeaddress !== prev_addr || oWM_writedata !== prev_data))
      stall_bad++;
    if (wr && st) begin
      stall_cycles++;
      prev_stall = 1'b1;
      prev_addr  = oWM_writeaddress;
      prev_data  = oWM_writedata;
    end else begin
      prev_stall = 1'b0;
    end
    if (wr && !st) begin
      beat_cnt++;
      if (exp_addr.size() == 0 || exp_data.size() == 0) extra_beats++;
      else begin
        chk("beat_addr", oWM_writeaddress, exp_addr.pop_front());
        chk("beat_data", oWM_writedata, exp_data.pop_front());
`ifdef WM_BYTEENABLE_EN
        if (exp_be.size() != 0) chk("beat_be", oWM_byteenable, exp_be.pop_front());
`endif
      end
    end
    if (Done) begin
      done_cnt++;
      done_cyc = cyc_n;
    end
    @(posedge iClk);
    #1;
    cyc_n++;
    if (rd && !emp && fifo.size() > 0) FF_q = fifo.pop_front();
    if (rand_mode) fifo_block = ($urandom_range(0, 3) == 0);
    FF_empty = fifo_block || (fifo.size() == 0);
    if (wr && wait_hold > 0) wait_hold--;
    iWM_waitrequest = (wait_hold > 0) ? 1'b1 : (rand_mode ? ($urandom_range(0, 2) == 0) : 1'b0);
  endtask

  task automatic push_word(input logic [31:0] w);
    fifo.push_back(w);
    exp_data.push_back(w);
    FF_empty = fifo_block || (fifo.size() == 0);
  endtask

  task automatic push_words(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) push_word($urandom);
  endtask

  function automatic int unsigned beats_for(input logic [31:0] len);
`ifdef WM_BYTEENABLE_EN
    return (len + 3) / 4;
`else
    return len / 4;
`endif
  endfunction

  // Expected beats: consecutive word addresses; partial final word only with byteenables.
  task automatic expect_beats(input logic [31:0] base, input logic [31:0] len);
    int unsigned nb;
    logic [3:0]  one;
    nb  = beats_for(len);
    one = 4'd1;
    for (int unsigned i = 0; i < nb; i++) begin
      exp_addr.push_back(base + 32'(4 * i));
      if (i == nb - 1 && (len % 4) != 0) exp_be.push_back((one << (len % 4)) - 4'd1);
      else exp_be.push_back(4'b1111);
    end
  endtask

  task automatic clear_counters();
    cyc_n = 1; done_cnt = 0; done_cyc = 0; first_wr_cyc = 0; pop_cnt = 0;
    beat_cnt = 0; stall_cycles = 0; stall_bad = 0; bad_pop = 0; extra_beats = 0;
    prev_stall = 1'b0;
  endtask

  task automatic start_xfer(input logic [31:0] base, input logic [31:0] len, input bit hold);
    expect_beats(base, len);
    WM_startaddress = base;
    Length          = len;
    Start           = 1'b1;
    cyc();
    if (!hold) Start = 1'b0;
    clear_counters();
    chk("busy_after_start", Busy, 1);
  endtask

  task automatic finish_xfer(input string tag, input int unsigned budget);
    int unsigned n = 0;
    while (done_cnt == 0 && n < budget) begin
      cyc();
      n++;
    end
    chk({tag, ":done_pulse"}, done_cnt, 1);
    chk({tag, ":busy_low"}, Busy, 0);
    cyc();
    chk({tag, ":single_done"}, done_cnt, 1);
    chk({tag, ":beats_left"}, exp_addr.size(), 0);
    chk({tag, ":extra_beats"}, extra_beats, 0);
    chk({tag, ":pop_when_empty"}, bad_pop, 0);
    chk({tag, ":stall_stable"}, stall_bad, 0);
  endtask

  initial begin
    logic [31:0] base;
    logic [31:0] len;
    int unsigned w2;
    int unsigned n;

    // Reset state
    repeat (2) cyc();
    chk("reset:write", oWM_write, 0);
    chk("reset:addr", oWM_writeaddress, 0);
    chk("reset:data", oWM_writedata, 0);
    chk("reset:pop", FF_readrequest, 0);
    chk("reset:busy", Busy, 0);
    chk("reset:done", Done, 0);
    iReset_n = 1'b1;
    cyc();

    // Basic 4-word transfer
    for (int unsigned i = 0; i < 4; i++) push_word(32'hA0 + 32'(i));
    start_xfer(32'h0000_1000, 32'd16, 1'b0);
    finish_xfer("basic", 60);
    chk("basic:first_write_cyc", first_wr_cyc, 3);
    chk("basic:done_cyc", done_cyc, 17);
    chk("basic:pops", pop_cnt, 4);
    chk("basic:beats", beat_cnt, 4);

    // Waitrequest held for 5 cycles on the first beat
    push_words(2);
    wait_hold = 5;
    iWM_waitrequest = 1'b1;
    start_xfer($urandom & ~32'h3, 32'd8, 1'b0);
    finish_xfer("stall", 60);
    chk("stall:stall_cycles", stall_cycles, 5);
    chk("stall:done_cyc", done_cyc, 14);
    chk("stall:pops", pop_cnt, 2);

    // FIFO underrun: two words, 20+ empty cycles, then the third
    push_words(2);
    start_xfer($urandom & ~32'h3, 32'd12, 1'b0);
    repeat (28) cyc();
    chk("underrun:beats_before", beat_cnt, 2);
    chk("underrun:pops_before", pop_cnt, 2);
    chk("underrun:busy", Busy, 1);
    push_words(1);
    finish_xfer("underrun", 30);
    chk("underrun:pops", pop_cnt, 3);

    // Zero / short lengths
    start_xfer($urandom & ~32'h3, 32'd0, 1'b0);
    finish_xfer("len0", 10);
    chk("len0:done_cyc", done_cyc, 1);
    chk("len0:beats", beat_cnt, 0);
    chk("len0:pops", pop_cnt, 0);
`ifdef WM_BYTEENABLE_EN
    push_words(2);
    start_xfer($urandom & ~32'h3, 32'd6, 1'b0);
    finish_xfer("len6", 40);
    chk("len6:beats", beat_cnt, 2);
    push_words(1);
    start_xfer($urandom & ~32'h3, 32'd3, 1'b0);
    finish_xfer("len3", 20);
    chk("len3:beats", beat_cnt, 1);
`else
    start_xfer($urandom & ~32'h3, 32'd3, 1'b0);
    finish_xfer("len3", 10);
    chk("len3:done_cyc", done_cyc, 1);
    chk("len3:beats", beat_cnt, 0);
    chk("len3:pops", pop_cnt, 0);
`endif

    // Reset while a write is stalled
    push_words(2);
    wait_hold = 1000;
    iWM_waitrequest = 1'b1;
    start_xfer($urandom & ~32'h3, 32'd8, 1'b0);
    n = 0;
    while (!oWM_write && n < 10) begin
      cyc();
      n++;
    end
    chk("rst:in_write", oWM_write, 1);
    #1 iReset_n = 1'b0;
    #1;
    chk("rst:write", oWM_write, 0);
    chk("rst:addr", oWM_writeaddress, 0);
    chk("rst:data", oWM_writedata, 0);
    chk("rst:busy", Busy, 0);
    chk("rst:pop", FF_readrequest, 0);
    wait_hold = 0;
    iWM_waitrequest = 1'b0;
    fifo.delete();
    exp_addr.delete();
    exp_data.delete();
    exp_be.delete();
    FF_empty = 1'b1;
    done_cnt = 0;
    repeat (3) cyc();
    chk("rst:no_done", done_cnt, 0);
    iReset_n = 1'b1;
    cyc();
    push_words(1);
    start_xfer($urandom & ~32'h3, 32'd4, 1'b0);
    finish_xfer("rst_restart", 20);
    chk("rst_restart:done_cyc", done_cyc, 5);

    // Address wrap, with Start held high through Done for a back-to-back transfer
    push_words(2);
    start_xfer(32'hFFFF_FFFC, 32'd8, 1'b1);
    base = $urandom & ~32'h3;
    w2   = $urandom_range(1, 3);
    WM_startaddress = base;
    Length          = 32'(w2 * 4);
    push_words(w2);
    finish_xfer("wrap", 40);
    chk("wrap:beats", beat_cnt, 2);
    Start = 1'b0;
    chk("b2b:busy_restart", Busy, 1);
    clear_counters();
    expect_beats(base, 32'(w2 * 4));
    finish_xfer("b2b", 60);
    chk("b2b:done_cyc", done_cyc, 4 * w2 + 1);

    // Randomized transfers with random waitrequest and FIFO gaps
    rand_mode = 1'b1;
    for (int unsigned t = 0; t < 8; t++) begin
      base = $urandom & ~32'h3;
      len  = 32'($urandom_range(0, 40));
      push_words(beats_for(len));
      start_xfer(base, len, 1'b0);
      finish_xfer("rand", 800);
      chk("rand:pops", pop_cnt, beats_for(len));
    end
    rand_mode  = 1'b0;
    fifo_block = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/dma_write_master.md
Name: dma_write_master

Overview:
- Write-side DMA engine. It drains 32-bit words from the DMA data FIFO and issues single-beat Avalon-MM writes to consecutive word addresses.
- It is the counterpart of the DMAC read master: the read master fills the FIFO, this block empties it to the destination.
- One transfer is launched per Start and is described by a start address and a byte length. A one-cycle Done pulse marks completion.

Parameters:
- DATA_WIDTH, 32, FIFO and Avalon data width (fixed word = 4 bytes).
- ADDR_WIDTH, 32, Avalon address width.

Ports:
- iClk  input  1  clock
- iReset_n  input  1  asynchronous active-low reset
- Start  input  1  launch transfer; sampled only in IDLE
- Length  input  32  transfer length in bytes
- WM_startaddress  input  ADDR_WIDTH  destination byte address, word aligned
- FF_empty  input  1  FIFO empty flag
- FF_q  input  DATA_WIDTH  FIFO read data, valid 1 cycle after FF_readrequest
- FF_readrequest  output  1  FIFO pop, 1-cycle pulse
- oWM_write  output  1  Avalon write request
- oWM_writeaddress  output  ADDR_WIDTH  Avalon write address
- oWM_writedata  output  DATA_WIDTH  Avalon write data
- iWM_waitrequest  input  1  Avalon slave stall
- Busy  output  1  high from Start acceptance until the Done cycle, inclusive
- Done  output  1  1-cycle completion pulse

Behaviour:
- Reset values: all outputs 0, state IDLE, internal counters 0. Reset is asynchronous and aborts any transfer; an in-flight Avalon write is dropped and no Done pulse is issued.
- States: IDLE, POP, LATCH, WRITE, ADVANCE, DONE. All outputs are registered.
- IDLE:
  - Start=1 and Length[31:2]!=0: load addr<=WM_startaddress, remaining<=Length with Length[1:0] cleared; Busy<=1; go to POP.
  - Start=1 and Length<4: go directly to DONE; no FIFO or bus activity.
- POP:
  - FF_empty=0: FF_readrequest=1 for exactly one cycle; go to LATCH.
  - FF_empty=1: stay in POP; no pop is issued.
- LATCH: oWM_writedata<=FF_q, oWM_writeaddress<=addr, oWM_write<=1; go to WRITE.
- WRITE:
  - oWM_write, address and data stay stable while iWM_waitrequest=1.
  - The beat is accepted on the first cycle with oWM_write=1 and iWM_waitrequest=0. On that cycle: oWM_write<=0, go to ADVANCE.
- ADVANCE: addr<=addr+4, remaining<=remaining-4. If remaining==4 go to DONE, else go to POP.
- DONE: Done=1 for one cycle, Busy<=0, go to IDLE.
- Arithmetic:
  - Address wraps modulo 2^ADDR_WIDTH with no error.
  - remaining is a 32-bit byte counter and never underflows: it only decrements when remaining>=4.
- Start while Busy is ignored. Start held high across DONE starts a new transfer in the following IDLE cycle.
- Latency:
  - Start to first oWM_write: 3 cycles when the FIFO is non-empty.
  - Minimum 4 cycles per word with zero waitrequest.
- FIFO underrun stalls in POP indefinitely; there is no timeout.
- Throughput is secondary; correctness and one-outstanding-write ordering are required.

Optional Feature:
- Macro WM_BYTEENABLE_EN.
- Defined:
  - Adds output oWM_byteenable, 4 bits.
  - Length[1:0] is honoured: a non-multiple-of-4 length produces one extra final write.
  - Final beat byteenable: 0001 for remainder 1, 0011 for 2, 0111 for 3, little-endian. All other beats use 1111.
  - Length 1..3 produces one partial write.
- Undefined: no byteenable port; Length[1:0] is ignored, so the transfer is truncated to whole words.

Decomposition:
- Shared package dmac_pkg:
  - state encoding constants (IDLE..DONE)
  - WORD_BYTES=4
  - byteenable lookup constants
- Sub-module dma_wm_counter, natural but optional: holds the address/remaining register pair with load and advance inputs and a last-word flag. It is reusable by the read master.

Test Plan:
- Basic transfer.
  - Stimulus: Start, WM_startaddress=0x1000, Length=16; FIFO preloaded with 0xA0..0xA3; waitrequest=0.
  - Response: writes 0xA0@0x1000, 0xA1@0x1004, 0xA2@0x1008, 0xA3@0x100C; exactly 4 pops; one Done pulse.
- Waitrequest stall.
  - Stimulus: Length=8; waitrequest held high for 5 cycles on the first beat.
  - Response: address and data stable for all 6 cycles; one write accepted per word; no extra pops.
- FIFO underrun.
  - Stimulus: Length=12; FIFO delivers words 1 and 2, stays empty for 20 cycles, then delivers word 3.
  - Response: FF_readrequest never asserted while FF_empty=1; third write to base+8 follows once data arrives.
- Zero or short length.
  - Stimulus: Length=0, and Length=3 without WM_BYTEENABLE_EN.
  - Response: Done one cycle after Start is accepted; no writes, no pops.
  - With WM_BYTEENABLE_EN, Length=6: two writes, byteenable 1111 then 0011.
- Reset and restart.
  - Stimulus: assert iReset_n low during WRITE with waitrequest=1.
  - Response: all outputs 0 immediately; no Done pulse. A new Start, Length=4 completes normally.
- Wrap and back-to-back.
  - Stimulus: WM_startaddress=0xFFFFFFFC, Length=8.
  - Response: writes to 0xFFFFFFFC then 0x00000000.
  - Start held high through Done starts a second transfer in the next IDLE cycle.
